// File: rtl/aes_out_serializer.sv
// Block FIFO that streams 128-bit AES results out one byte per cycle, byte 0 (MSB) first.
// Optional even-parity output port out_parity is enabled by defining SER_PARITY_EN.
module aes_out_serializer #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [127:0]             in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    input  logic                     out_ready,
    output logic                     out_last,
`ifdef SER_PARITY_EN
    output logic                     out_parity,
`endif
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [127:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [3:0]    idx;

    logic          push;
    logic          xfer;
    logic          pop;
    logic [127:0]  head;
    logic [3:0]    byte_sel;

    // Handshake flags come from registered count only, so out_ready never reaches in_ready
    // and in_valid never reaches out_valid combinationally.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign pop       = xfer && (idx == 4'd15);

    assign head     = mem[rd_ptr];
    assign byte_sel = 4'd15 - idx;

    // NOTE: out_data gets its default first so no path through this block can infer a latch.
    always_comb begin
        out_data = 8'h00;
        if (out_valid) begin
            out_data = head[{byte_sel, 3'b000} +: 8];
        end
    end

    assign out_last = out_valid && (idx == 4'd15);
    assign level    = count;

`ifdef SER_PARITY_EN
    assign out_parity = ^out_data;
`endif

    // NOTE: the block storage is deliberately not reset; stale entries are unreachable once
    // the pointers and count are cleared, and leaving it out keeps the array a plain RAM.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            idx    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (xfer) begin
                idx <= idx + 1'b1;
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_out_serializer.sv
// Scoreboard bench for aes_out_serializer: expected bytes are queued on each accepted push
// and compared against every byte the DUT presents.
module tb_aes_out_serializer;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [127:0]  in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic [LW-1:0] level;
`ifdef SER_PARITY_EN
    logic          out_parity;
`endif

    aes_out_serializer #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_last  (out_last),
`ifdef SER_PARITY_EN
        .out_parity(out_parity),
`endif
        .level     (level)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   xfers      = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [127:0] b, input int i);
        return b[127 - 8 * i -: 8];
    endfunction

    function automatic logic [127:0] rand_block();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic sb_push_block(input logic [127:0] b);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.data = byte_of(b, i);
            e.last = (i == 15);
            sb.push_back(e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Offers a block until accepted; waited counts the edges spent with in_ready low.
    task automatic push_block(input logic [127:0] b, output int waited);
        waited   = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waited < 200) begin
            tick(1);
            waited++;
        end
        if (!in_ready) begin
            check("push_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clock);
        sb_push_block(b);
        #1;
        in_valid = 1'b0;
        in_data  = rand_block();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 400 && (sb.size() != 0 || out_valid); i++) begin
            tick(1);
        end
        check("drain_sb_empty", sb.size(), 0);
        check("drain_out_valid", out_valid, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_level"}, level, 0);
    endtask

    // Output monitor on the falling edge, clear of the active edge.
    exp_t mon_e;
    always @(negedge clock) begin
        if (!reset) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_byte", 1, 0);
                end else begin
                    mon_e = sb[0];
                    if (out_ready) check("byte", out_data, mon_e.data);
                    else           check("stall_byte", out_data, mon_e.data);
                    check("last", out_last, mon_e.last);
`ifdef SER_PARITY_EN
                    check("parity", out_parity, ^mon_e.data);
`endif
                    if (out_ready) begin
                        void'(sb.pop_front());
                        xfers++;
                    end
                end
            end else begin
                check("idle_data", out_data, 0);
                check("idle_last", out_last, 0);
                if (sb.size() != 0) check("missing_byte", 0, 1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [127:0] fill [5];
    logic [127:0] blk_a;
    logic [127:0] blk_b;
    int           w;
    int           n0;

    initial begin
        // Power-on reset
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        check_reset_outputs("por");

        // Single block: 00..0F back to back, byte 0 the cycle after the push
        out_ready = 1'b1;
        push_block(128'h000102030405060708090A0B0C0D0E0F, w);
        n0 = xfers;
        check("single_lat_valid", out_valid, 1);
        check("single_lat_byte0", out_data, 8'h00);
        check("single_level_1", level, 1);
        tick(15);
        check("single_level_before_last", level, 1);
        check("single_last_now", out_last, 1);
        check("single_byte_0f", out_data, 8'h0F);
        tick(1);
        check("single_level_0", level, 0);
        check("single_xfer_count", xfers - n0, 16);
        drain();

        // Fill with sink stalled, then release and time the fifth acceptance
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) fill[i] = rand_block() ^ 128'(i);
        for (int i = 0; i < 4; i++) push_block(fill[i], w);
        check("fill_level_4", level, 4);
        check("fill_in_ready_0", in_ready, 0);
        in_valid = 1'b1;
        in_data  = fill[4];
        tick(3);
        check("fill_held_level", level, 4);
        check("fill_held_ready", in_ready, 0);
        out_ready = 1'b1;
        push_block(fill[4], w);
        check("fill_fifth_wait", w, 16);
        check("fill_level_after", level, 4);
        drain();

        // Stall stability under random backpressure over three blocks
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_block(rand_block(), w);
        check("stall_level_3", level, 3);
        for (int i = 0; i < 600 && (sb.size() != 0 || out_valid); i++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick(1);
        end
        drain();

        // Push on the same edge as the head's final byte transfer
        out_ready = 1'b0;
        blk_a = rand_block();
        blk_b = rand_block();
        push_block(blk_a, w);
        push_block(blk_b, w);
        check("simul_level_2", level, 2);
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (out_last) break;
        end
        check("simul_last_seen", out_last, 1);
        #1;
        push_block(rand_block(), w);
        check("simul_no_wait", w, 0);
        check("simul_level_stays_2", level, 2);
        check("simul_next_byte0", out_data, byte_of(blk_b, 0));
        drain();

        // Reset after seven bytes of a block, then a fresh block starts at byte 0
        out_ready = 1'b0;
        push_block(rand_block(), w);
        push_block(rand_block(), w);
        out_ready = 1'b1;
        tick(7);
        reset = 1'b1;
        sb.delete();
        tick(2);
        reset = 1'b0;
        out_ready = 1'b0;
        check_reset_outputs("midrst");
        blk_b = rand_block();
        push_block(blk_b, w);
        check("midrst_first_byte", out_data, byte_of(blk_b, 0));
        check("midrst_level", level, 1);
        drain();

        check("final_sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
